// File: rtl/mem_fill_if.sv
// mem_fill_if: memory read handshake plus wb-stage writeback bus for mem_fill.
//   master (fill engine): drives mem_rd_req/mem_addr/wb_en_out/ptr_out/val_out, samples mem_rd_ack/mem_rd_data
//   slave  (memory + wb): the mirror image
interface mem_fill_if;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack;
  logic [15:0] mem_rd_data;
  logic        wb_en_out;
  logic [15:0] ptr_out;
  logic [15:0] val_out;
  modport master (output mem_rd_req, mem_addr, wb_en_out, ptr_out, val_out,
                  input  mem_rd_ack, mem_rd_data);
  modport slave  (input  mem_rd_req, mem_addr, wb_en_out, ptr_out, val_out,
                  output mem_rd_ack, mem_rd_data);
endinterface

// File: rtl/mem_fill.sv
// mem_fill: round-robin fill engine that reads memory for locked RF entries and pulses a wb writeback.
//   clk, rst      : clock, synchronous active-high reset
//   rf_in         : packed RF, entry i = {valid, retr, locked, tag[15:0], val[15:0]}
//   bus (master)  : memory read handshake and wb writeback strobe/tag/value
//   busy          : engine not idle
//   fill_err      : sticky read-timeout flag; only built with MEM_FILL_TIMEOUT_EN defined
module mem_fill #(
  parameter int NCORES  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES*35-1:0] rf_in,
  mem_fill_if.master           bus,
  output logic                 busy,
  output logic                 fill_err
);
  localparam int RW = NCORES > 1 ? $clog2(NCORES) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WB, HOLD} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] rr_q, rr_d, sel, idx;
  logic [15:0] ptr_q, ptr_d, pout_q, pout_d, vout_q, vout_d;
  logic hold_q, hold_d, found;
  logic [NCORES-1:0] cand;
  logic unused_rf;
  assign unused_rf = ^rf_in;
`ifdef MEM_FILL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign fill_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign fill_err = 1'b0;
`endif
  always_comb begin
    for (int i = 0; i < NCORES; i++) cand[i] = &rf_in[i*35+32 +: 3];
  end
  // first candidate at or after rr, wrapping
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int j = 0; j < NCORES; j++) begin
      idx = RW'((int'(rr_q) + j) % NCORES);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    ptr_d = ptr_q;
    pout_d = pout_q;
    vout_d = vout_q;
    hold_d = 1'b0;
`ifdef MEM_FILL_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef MEM_FILL_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (found) begin
          state_d = REQ;
          ptr_d = rf_in[int'(sel)*35+16 +: 16];
          rr_d = (int'(sel) == NCORES-1) ? '0 : sel + 1'b1;
        end
      end
      REQ: begin
        if (bus.mem_rd_ack) begin
          state_d = WB;
          pout_d = ptr_q;
          vout_d = bus.mem_rd_data;
        end
`ifdef MEM_FILL_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = HOLD;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 16'd1;
`endif
      end
      WB: state_d = HOLD;
      HOLD: begin
        hold_d = ~hold_q;
        state_d = hold_q ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      ptr_q <= '0;
      pout_q <= '0;
      vout_q <= '0;
      hold_q <= 1'b0;
`ifdef MEM_FILL_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      ptr_q <= ptr_d;
      pout_q <= pout_d;
      vout_q <= vout_d;
      hold_q <= hold_d;
`ifdef MEM_FILL_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign bus.mem_rd_req = state_q == REQ;
  assign bus.mem_addr = ptr_q;
  assign bus.wb_en_out = state_q == WB;
  assign bus.ptr_out = pout_q;
  assign bus.val_out = vout_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/mem_fill.md
# mem_fill

Fill engine directly upstream of the `wb` stage. It scans the packed register-file vector for entries awaiting a memory value (valid, retrieving, locked) and arbitrates among them round-robin. It performs one handshaked read of the data memory per fill and drives the `wb` stage's `wb_en_in`/`ptr_in`/`val_in` with a one-cycle writeback pulse. A single fill services every core whose tag matches, since `wb` unlocks all matching entries.

## Interface
- `NCORES`, 4, number of register-file entries (one per core); ≥1
- `TIMEOUT`, 255, cycles to wait for `mem_rd_ack` before abort; 1..65535; used only with `MEM_FILL_TIMEOUT_EN`

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `rf_in`  in  NCORES*35  packed RF; entry i at `[i*35 +: 35]` = {valid[34], retr[33], locked[32], tag[31:16], val[15:0]}
- `mem_rd_req`  out  1  read request, held until ack
- `mem_addr`  out  16  read address (= selected tag); stable while `mem_rd_req`
- `mem_rd_ack`  in  1  read complete; `mem_rd_data` valid same cycle
- `mem_rd_data`  in  16  read data
- `wb_en_out`  out  1  one-cycle writeback strobe → `wb.wb_en_in`
- `ptr_out`  out  16  writeback tag → `wb.ptr_in`
- `val_out`  out  16  writeback value → `wb.val_in`
- `busy`  out  1  state ≠ IDLE
- `fill_err`  out  1  sticky timeout flag (0 when macro absent)

## Operation
- Candidate i: `valid & retr & locked`. Entries with `locked=0` are never candidates; `wb` clears `locked`, which retires the entry.
- Selection: first candidate at or after `rr` in index order (wrapping at NCORES-1 → 0). On selection, `rr <= (sel+1) mod NCORES`. Width of `rr` is `$clog2(NCORES)`, minimum 1. NCORES=1 keeps `rr=0`.
- FSM states:
  - IDLE: if any candidate, latch `ptr <= tag[sel]`, update `rr`, go to REQ. Otherwise stay.
  - REQ: `mem_rd_req=1`, `mem_addr=ptr`. On `mem_rd_ack`, latch `val <= mem_rd_data` and go to WB.
  - WB: `wb_en_out=1`, `ptr_out=ptr`, `val_out=val` for exactly one cycle, then go to HOLD.
  - HOLD: 2 cycles, then IDLE. This covers `wb`'s input register plus the RF register, so a just-filled entry is not reselected.
- `ptr_out` and `val_out` hold their last values when `wb_en_out=0`. `wb` ignores them then.
- `mem_rd_ack` outside REQ is ignored.
- Duplicate tags across cores: one fill; all matching entries unlock together in `wb`.
- The `rf_in` value at the selection edge is used. Later changes to `rf_in` do not abort an in-flight fill.

## Timing
- Reset (sync): state=IDLE, `rr=0`, `mem_rd_req=0`, `mem_addr=0`, `wb_en_out=0`, `ptr_out=0`, `val_out=0`, `busy=0`, `fill_err=0`, timeout counter=0.
- Reset mid-fill: at the reset edge all outputs go to reset values and the outstanding request is abandoned. A late ack is ignored.
- Latency: candidate visible in cycle 0 → `mem_rd_req` high cycle 1 → ack in cycle k≥1 → `wb_en_out` high cycle k+1 → IDLE in cycle k+4.
- Minimum spacing between fills: 5 cycles, with 0-wait memory.
- `mem_rd_req` falls on the edge after the ack cycle. The memory must not re-ack the same request.

## Configuration
- `MEM_FILL_TIMEOUT_EN` defined:
  - A 16-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT` with no ack: drop `mem_rd_req`, set `fill_err` (sticky until `rst`), skip WB, and go to HOLD.
  - The entry stays locked and is reselected later by round-robin.
  - An ack arriving in the same cycle as the limit wins, and the fill completes normally.
- `MEM_FILL_TIMEOUT_EN` undefined: REQ waits indefinitely, no counter is built, and `fill_err` is tied 0.

## Test plan
- NCORES=4, entry 2 = {1,1,1,0x0040,x}, memory acks in the 1st REQ cycle with 0xBEEF: `mem_rd_req` high for 1 cycle with `mem_addr=0x0040`; `wb_en_out` one-cycle pulse with `ptr_out=0x0040`, `val_out=0xBEEF`; `busy` low 3 cycles later.
- Entries 0, 1 and 3 are all candidates and held until filled: service order 0, 1, 3. Then re-arm entry 0 only: it is serviced next, and `rr` wraps correctly.
- Entries 0 and 3 both carry tag 0x0100: exactly one memory request is issued, and the single `wb` pulse unlocks both entries.
- Memory delays ack by 7 cycles: `mem_rd_req` and `mem_addr` stay stable for 8 cycles, and `wb_en_out` rises the cycle after ack.
- Assert `rst` on the 3rd REQ cycle, then ack on the next cycle: `mem_rd_req=0` and state IDLE immediately after reset, with no `wb_en_out` pulse.
- With `MEM_FILL_TIMEOUT_EN` and TIMEOUT=4, memory never acks: `mem_rd_req` drops after 4 cycles, `fill_err=1` and stays set, there is no `wb` pulse, and the same entry is re-requested after HOLD.
